morse_element_tx: RTL and testbench
===================================

# morse_element_tx

Morse element transmitter: accepts one symbol per valid/ready handshake (dot, dash, letter gap, word gap) and drives a single key line with standard Morse timing in integer units of `UNIT_TICKS` clock cycles. It is the sending end of the Morse path and the counterpart of the receive-side duration accumulation logic. It sits between the character-to-symbol sequencer (upstream) and the tone/LED driver (downstream, fed by `KEY`).

## Interface
- `UNIT_TICKS`, default 6_000_000: clock cycles per Morse unit (60 ms at 100 MHz); legal range ≥ 2.
- `clk` input 1: system clock; all logic on posedge.
- `CLR_n` input 1: synchronous, active-low reset.
- `SYM` input 2: symbol code: 00 DOT, 01 DASH, 10 LGAP, 11 WGAP.
- `VALID` input 1: `SYM` is valid this cycle.
- `READY` output 1: block accepts a symbol this cycle; transfer occurs when `VALID && READY`.
- `KEY` output 1: key line, registered; 1 = tone on.
- `BUSY` output 1: registered; 1 while a symbol is in progress.
- `DONE` output 1: one-cycle pulse on the final cycle of each symbol.

## Operation
- Single clock; reset is synchronous and active-low.
- States:
  - IDLE: `READY`=1, `KEY`=0.
  - MARK: `KEY`=1, lasts mark units.
  - SPACE: `KEY`=0, lasts space units.
- Unit counts per symbol:
  - DOT: 1 unit mark, then 1 unit space.
  - DASH: 3 units mark, then 1 unit space.
  - LGAP: no mark, 2 units space. Together with the preceding element's 1-unit space this gives 3 units.
  - WGAP: no mark, 6 units space. Together with the preceding element's 1-unit space this gives 7 units.
- Accept:
  - DOT/DASH: go to MARK.
  - LGAP/WGAP: go directly to SPACE.
  - `SYM` is captured on acceptance; later changes to `SYM` have no effect.
- Tick counter: counts 0..`UNIT_TICKS`-1; width is $clog2(`UNIT_TICKS`). Unit counter: 3 bits, loaded with (units − 1), decremented on tick wrap.
- MARK end: after the last unit, go to SPACE with count 1.
- SPACE end: on the last cycle of the last unit, `DONE`=1 and `READY`=1.
  - If `VALID` is high in that cycle, the next symbol starts on the following edge. There is no idle cycle, so gap timing is exact.
  - Otherwise go to IDLE.
- `READY` is combinational: (state==IDLE || SPACE last cycle) && `CLR_n`.
- `VALID` while not `READY` is ignored. No buffering.
- Reset, including mid-symbol: next edge forces IDLE, `KEY`=0, `BUSY`=0, `DONE`=0, and clears both counters. `READY`=0 while `CLR_n`=0 and 1 on the first cycle after release.

## Timing
- Accept at edge t: `KEY` rises at t+1 (DOT/DASH), `BUSY` rises at t+1.
- Mark duration: exactly units×`UNIT_TICKS` cycles.
- Space duration: exactly units×`UNIT_TICKS` cycles.
- Total symbol length: DOT 2U, DASH 4U, LGAP 2U, WGAP 6U cycles, where U=`UNIT_TICKS`. `DONE` is asserted in the last of these cycles.
- `BUSY` falls the cycle after `DONE` unless a new symbol was accepted in the `DONE` cycle.
- No combinational path from `VALID`/`SYM` to `KEY`, `BUSY` or `DONE`.

## Structure
- Shared package `morse_pkg` holds:
  - `sym_t` enum: DOT, DASH, LGAP, WGAP.
  - `state_t` enum: IDLE, MARK, SPACE.
  - Constants: DOT_UNITS=1, DASH_UNITS=3, ELEM_GAP_UNITS=1, LGAP_UNITS=2, WGAP_UNITS=6.
- The package is shared with the receive-side decoder.
- One sub-module, `morse_unit_timer`: prescaler that emits a one-cycle `TICK` on count wrap, with a synchronous `RESTART` input.
- The FSM and unit counter live in the top module.

## Test plan
All scenarios use `UNIT_TICKS`=4.
- DOT accepted at cycle 0 -> `KEY`=1 in cycles 1–4, 0 in 5–8; `DONE` in cycle 8; `READY`=0 in cycles 1–7.
- DASH -> `KEY`=1 for 12 cycles, 0 for 4; `DONE` on cycle 16 after acceptance.
- DOT, DOT, WGAP with `VALID` held high -> `KEY` high 4 / low 4 / high 4 / low 4, then low 24 cycles; second and third accepts occur exactly on the `DONE` cycles.
- `SYM` toggled and `VALID` pulsed while in MARK -> ignored; waveform identical to the single-symbol case.
- `CLR_n` low at cycle 6 of a DASH -> `KEY`=0, `BUSY`=0 at cycle 7, no `DONE`; a DOT accepted after release produces a clean 4/4 pattern.
- LGAP from IDLE -> `KEY` stays 0; `DONE` after 8 cycles.

Source files
------------

// File: rtl/morse_pkg.sv
// Morse symbol codes, element timing and FSM states, shared by the transmitter and the receive-side decoder.
package morse_pkg;

    typedef enum logic [1:0] {
        DOT  = 2'b00,
        DASH = 2'b01,
        LGAP = 2'b10,
        WGAP = 2'b11
    } sym_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        MARK  = 2'b01,
        SPACE = 2'b10
    } state_t;

    localparam int DOT_UNITS      = 1;
    localparam int DASH_UNITS     = 3;
    localparam int ELEM_GAP_UNITS = 1;
    localparam int LGAP_UNITS     = 2;
    localparam int WGAP_UNITS     = 6;

    // Gap symbols carry no mark; their first (and only) phase is the space.
    function automatic logic has_mark(input sym_t s);
        return (s == DOT) || (s == DASH);
    endfunction

    // Unit counter load value (units - 1) for the first phase of a symbol.
    function automatic logic [2:0] first_phase_load(input sym_t s);
        logic [2:0] load;
        case (s)
            DOT:     load = 3'(DOT_UNITS - 1);
            DASH:    load = 3'(DASH_UNITS - 1);
            LGAP:    load = 3'(LGAP_UNITS - 1);
            default: load = 3'(WGAP_UNITS - 1);
        endcase
        return load;
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Unit prescaler: counts 0..UNIT_TICKS-1 and flags the last cycle of each unit with TICK.
module morse_unit_timer #(
    parameter int UNIT_TICKS = 6_000_000
) (
    input  logic clk,
    input  logic CLR_n,
    input  logic RESTART,
    output logic TICK
);

    localparam int TW = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;
    localparam logic [TW-1:0] LAST = TW'(UNIT_TICKS - 1);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!CLR_n || RESTART) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign TICK = (cnt_q == LAST);

endmodule

// File: rtl/morse_element_tx.sv
// Morse element transmitter: takes one symbol per handshake and keys KEY with unit-exact mark/space timing.
// Holds the IDLE/MARK/SPACE FSM and the unit counter; morse_unit_timer supplies the unit ticks.
module morse_element_tx
    import morse_pkg::*;
#(
    parameter int UNIT_TICKS = 6_000_000
) (
    input  logic       clk,
    input  logic       CLR_n,
    input  logic [1:0] SYM,
    input  logic       VALID,
    output logic       READY,
    output logic       KEY,
    output logic       BUSY,
    output logic       DONE,
    output state_t     dbg_state
);

    // Handshake: a symbol transfers on any posedge where VALID && READY; READY is high in IDLE
    // and in the final cycle of a symbol's space, so back-to-back symbols leave no idle cycle.
    state_t     state_q, state_d;
    logic [2:0] unit_q, unit_d;
    logic       tick;
    logic       timer_restart;
    logic       last_unit;
    logic       space_end;
    logic       accept;
    sym_t       sym_in;

    morse_unit_timer #(
        .UNIT_TICKS(UNIT_TICKS)
    ) u_timer (
        .clk    (clk),
        .CLR_n  (CLR_n),
        .RESTART(timer_restart),
        .TICK   (tick)
    );

    always_comb begin
        state_d       = state_q;
        unit_d        = unit_q;
        timer_restart = 1'b0;
        sym_in        = sym_t'(SYM);
        last_unit     = tick && (unit_q == 3'd0);
        space_end     = (state_q == SPACE) && last_unit;
        READY         = ((state_q == IDLE) || space_end) && CLR_n;
        accept        = READY && VALID;

        case (state_q)
            IDLE: begin
                timer_restart = 1'b1;
            end
            MARK: begin
                if (last_unit) begin
                    state_d = SPACE;
                    unit_d  = 3'(ELEM_GAP_UNITS - 1);
                end else if (tick) begin
                    unit_d = unit_q - 3'd1;
                end
            end
            SPACE: begin
                if (last_unit) begin
                    state_d = IDLE;
                end else if (tick) begin
                    unit_d = unit_q - 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Acceptance overrides the end-of-space return to IDLE.
        if (accept) begin
            timer_restart = 1'b1;
            unit_d        = first_phase_load(sym_in);
            state_d       = has_mark(sym_in) ? MARK : SPACE;
        end
    end

    always_ff @(posedge clk) begin
        if (!CLR_n) begin
            state_q <= IDLE;
            unit_q  <= 3'd0;
            KEY     <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            state_q <= state_d;
            unit_q  <= unit_d;
            KEY     <= (state_d == MARK);
            BUSY    <= (state_d != IDLE);
        end
    end

    assign DONE      = space_end;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_morse_element_tx.sv
// Bench for morse_element_tx with UNIT_TICKS=4: directed timing scenarios plus random traffic
// checked every cycle against a symbol-level model (cycle index within the current symbol).
module tb_morse_element_tx;
    import morse_pkg::*;

    localparam int U = 4;

    // clock / reset block
    logic       clk = 1'b0;
    logic       CLR_n = 1'b0;
    logic [1:0] SYM = 2'b00;
    logic       VALID = 1'b0;
    logic       READY, KEY, BUSY, DONE;
    state_t     dut_state;

    always #5 clk = ~clk;

    morse_element_tx #(
        .UNIT_TICKS(U)
    ) dut (
        .clk      (clk),
        .CLR_n    (CLR_n),
        .SYM      (SYM),
        .VALID    (VALID),
        .READY    (READY),
        .KEY      (KEY),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .dbg_state(dut_state)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
        end
    endtask

    // Behavioural model: a symbol lasts sym_len cycles, KEY is high for its first mark_len cycles.
    function automatic int sym_len(input logic [1:0] s);
        case (s)
            2'b00:   return 2 * U;
            2'b01:   return 4 * U;
            2'b10:   return 2 * U;
            default: return 6 * U;
        endcase
    endfunction

    function automatic int mark_len(input logic [1:0] s);
        case (s)
            2'b00:   return 1 * U;
            2'b01:   return 3 * U;
            default: return 0;
        endcase
    endfunction

    bit m_active = 1'b0;
    int m_k = 0;
    int m_len = 0;
    int m_mark = 0;

    always @(posedge clk) begin
        if (!CLR_n) begin
            m_active <= 1'b0;
        end else if ((!m_active || m_k == m_len) && VALID) begin
            m_active <= 1'b1;
            m_k      <= 1;
            m_len    <= sym_len(SYM);
            m_mark   <= mark_len(SYM);
        end else if (m_active) begin
            if (m_k == m_len) m_active <= 1'b0;
            else m_k <= m_k + 1;
        end
    end

    // scoreboard: every cycle, DUT outputs vs model
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_key",   KEY,   m_active && (m_k <= m_mark));
            check("model_busy",  BUSY,  m_active);
            check("model_done",  DONE,  m_active && (m_k == m_len));
            check("model_ready", READY, CLR_n && (!m_active || (m_k == m_len)));
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one symbol from an idle block and checks its waveform against hand timing.
    task automatic run_symbol(input logic [1:0] s, input string tag, input bit poke);
        int len, mark, done_at, done_cnt, rdy_lo, hi;
        case (s)
            2'b00:   begin mark = 4;  len = 8;  end
            2'b01:   begin mark = 12; len = 16; end
            2'b10:   begin mark = 0;  len = 8;  end
            default: begin mark = 0;  len = 24; end
        endcase
        done_at = 0; done_cnt = 0; rdy_lo = 0; hi = 0;
        VALID = 1'b1;
        SYM = s;
        step();
        VALID = 1'b0;
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            check({tag, "_key"}, KEY, (c <= mark));
            if (KEY) hi++;
            if (!READY) rdy_lo++;
            if (DONE) begin
                done_cnt++;
                done_at = c;
            end
            step();
            if (poke && c == 1) begin
                VALID = 1'b1;
                SYM = ~s;
            end
            if (poke && c == 2) begin
                VALID = 1'b0;
            end
        end
        check({tag, "_done_cycle"}, done_at, len);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_key_high"}, hi, mark);
        check({tag, "_ready_low"}, rdy_lo, len - 1);
        @(negedge clk);
        check({tag, "_busy_after"}, BUSY, 0);
        step();
    endtask

    int dcnt;

    initial begin
        // reset
        step();
        chk_en = 1'b1;
        step();
        @(negedge clk);
        check("reset_ready", READY, 0);
        check("reset_key", KEY, 0);
        check("reset_busy", BUSY, 0);
        check("reset_done", DONE, 0);
        step();
        CLR_n = 1'b1;
        @(negedge clk);
        check("release_ready", READY, 1);
        step();

        run_symbol(2'b00, "dot", 1'b0);
        run_symbol(2'b01, "dash", 1'b0);
        run_symbol(2'b00, "dot_poked", 1'b1);
        run_symbol(2'b01, "dash_poked", 1'b1);
        run_symbol(2'b10, "lgap", 1'b0);
        run_symbol(2'b11, "wgap", 1'b0);

        // DOT, DOT, WGAP with VALID held high
        dcnt = 0;
        VALID = 1'b1;
        SYM = 2'b00;
        step();
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            check("chain_key", KEY, (c <= 4) || (c >= 9 && c <= 12));
            check("chain_done", DONE, (c == 8) || (c == 16) || (c == 40));
            if (DONE) dcnt++;
            step();
            if (c == 8) SYM = 2'b11;
            if (c == 16) VALID = 1'b0;
        end
        check("chain_done_count", dcnt, 3);
        @(negedge clk);
        check("chain_busy_after", BUSY, 0);
        step();

        // reset in the middle of a DASH
        dcnt = 0;
        VALID = 1'b1;
        SYM = 2'b01;
        step();
        VALID = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c <= 6) check("abort_key_on", KEY, 1);
            if (c == 6) check("abort_ready_in_reset", READY, 0);
            if (c == 7) begin
                check("abort_key_off", KEY, 0);
                check("abort_busy_off", BUSY, 0);
                check("abort_ready_release", READY, 1);
            end
            if (DONE) dcnt++;
            step();
            if (c == 5) CLR_n = 1'b0;
            if (c == 6) CLR_n = 1'b1;
        end
        check("abort_no_done", dcnt, 0);
        run_symbol(2'b00, "post_reset_dot", 1'b0);

        // random traffic, checked by the scoreboard
        for (int i = 0; i < 3000; i++) begin
            VALID = 1'($urandom_range(0, 1));
            SYM = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0 && !(m_active && m_k == m_len)) CLR_n = 1'b0;
            else CLR_n = 1'b1;
            step();
        end
        CLR_n = 1'b1;
        VALID = 1'b0;
        for (int i = 0; i < 30; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
